// File: rtl/serial_pattern_tx_if.sv
// Host-side job handshake and serial output bundle for serial_pattern_tx.
// The host drives the job fields and start/abort; the transmitter drives the rest.
interface serial_pattern_tx_if #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 8
) ();
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic [CNT_W-1:0]   repeats;
  logic [CNT_W-1:0]   gap;
  logic               ready;
  logic               out;
  logic               out_valid;
  logic               frame_start;
  logic               done;

  modport master (
    output start, abort, pattern, length, repeats, gap,
    input  ready, out, out_valid, frame_start, done
  );

  modport slave (
    input  start, abort, pattern, length, repeats, gap,
    output ready, out, out_valid, frame_start, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it with optional idle gaps between frames, one bit per clock.
module serial_pattern_tx #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_pattern_tx_if.slave   bus
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = $clog2(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_frames_left;
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_gap_cnt;
  logic               r_ready;
  logic               r_out;
  logic               r_out_valid;
  logic               r_frame_start;
  logic               r_done;

  logic [1:0]         w_state_next;
  logic [MAX_LEN-1:0] w_pattern_next;
  logic [LEN_W-1:0]   w_len_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic [CNT_W-1:0]   w_frames_left_next;
  logic [CNT_W-1:0]   w_gap_next;
  logic [CNT_W-1:0]   w_gap_cnt_next;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [IDX_W-1:0]   w_last_idx;
  logic [IDX_W-1:0]   w_last_idx_next;
  logic               w_in_send_next;

  assign w_len_clamped   = (bus.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.length;
  assign w_last_idx      = IDX_W'(r_len - LEN_W'(1));
  assign w_last_idx_next = IDX_W'(w_len_next - LEN_W'(1));

  always_comb begin
    w_state_next       = r_state;
    w_pattern_next     = r_pattern;
    w_len_next         = r_len;
    w_idx_next         = r_idx;
    w_frames_left_next = r_frames_left;
    w_gap_next         = r_gap;
    w_gap_cnt_next     = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_pattern_next     = bus.pattern;
          w_len_next         = w_len_clamped;
          w_gap_next         = bus.gap;
          w_frames_left_next = bus.repeats;
          w_idx_next         = IDX_W'(w_len_clamped - LEN_W'(1));
          w_state_next       = (w_len_clamped == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          w_state_next = S_IDLE;
        end else if (r_idx == '0) begin
          if (r_frames_left == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_frames_left_next = r_frames_left - CNT_W'(1);
            w_idx_next         = w_last_idx;
            w_gap_cnt_next     = r_gap;
            w_state_next       = (r_gap == '0) ? S_SEND : S_GAP;
          end
        end else begin
          w_idx_next = r_idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          w_state_next = S_IDLE;
        end else if (r_gap_cnt == CNT_W'(1)) begin
          w_idx_next   = w_last_idx;
          w_state_next = S_SEND;
        end else begin
          w_gap_cnt_next = r_gap_cnt - CNT_W'(1);
        end
      end
      // The done pulse is already on the output here, so abort changes nothing.
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so each bit appears in
  // the same cycle its state is entered.
  assign w_in_send_next = (w_state_next == S_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pattern     <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_frames_left <= '0;
      r_gap         <= '0;
      r_gap_cnt     <= '0;
      r_ready       <= 1'b1;
      r_out         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pattern     <= w_pattern_next;
      r_len         <= w_len_next;
      r_idx         <= w_idx_next;
      r_frames_left <= w_frames_left_next;
      r_gap         <= w_gap_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_ready       <= (w_state_next == S_IDLE);
      r_out         <= w_in_send_next & w_pattern_next[w_idx_next];
      r_out_valid   <= w_in_send_next;
      r_frame_start <= w_in_send_next && (w_idx_next == w_last_idx_next);
      r_done        <= (w_state_next == S_DONE);
    end
  end

  assign bus.ready       = r_ready;
  assign bus.out         = r_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed and random jobs checked cycle by cycle
// against a per-cycle expectation list built from the job parameters.
module tb_serial_pattern_tx;
  localparam int MAX_LEN = 32;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic ready;
    logic out;
    logic valid;
    logic fs;
    logic done;
  } rec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  rec_t exp_q[$];

  serial_pattern_tx_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  serial_pattern_tx #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_rec(input string tag, input rec_t e);
    check({tag, ".ready"}, 32'(bus.ready), 32'(e.ready));
    check({tag, ".out"}, 32'(bus.out), 32'(e.out));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(e.valid));
    check({tag, ".fs"}, 32'(bus.frame_start), 32'(e.fs));
    check({tag, ".done"}, 32'(bus.done), 32'(e.done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.pattern = $urandom;
    bus.length  = 6'($urandom_range(0, 63));
    bus.repeats = 8'($urandom_range(0, 255));
    bus.gap     = 8'($urandom_range(0, 255));
  endtask

  // Expected per-cycle view of a job, starting with the cycle after acceptance.
  function automatic void build(input logic [31:0] pat, input int length, input int rep, input int gp);
    int   len;
    rec_t r;
    len = (length > MAX_LEN) ? MAX_LEN : length;
    exp_q.delete();
    if (len > 0) begin
      for (int f = 0; f <= rep; f++) begin
        for (int b = 0; b < len; b++) begin
          r = '{ready: 1'b0, out: pat[len-1-b], valid: 1'b1, fs: (b == 0), done: 1'b0};
          exp_q.push_back(r);
        end
        if (f < rep) begin
          for (int g = 0; g < gp; g++) exp_q.push_back(rec_t'(5'b0));
        end
      end
    end
    r = '{ready: 1'b0, out: 1'b0, valid: 1'b0, fs: 1'b0, done: 1'b1};
    exp_q.push_back(r);
  endfunction

  // abort_at / rst_at: 1-based job cycle at which to interrupt (0 = never).
  task automatic run_job(input logic [31:0] pat, input int length, input int rep, input int gp,
                         input int abort_at, input int rst_at, input bit busy);
    rec_t idle_r;
    int   len;
    idle_r = '{ready: 1'b1, out: 1'b0, valid: 1'b0, fs: 1'b0, done: 1'b0};
    len = (length > MAX_LEN) ? MAX_LEN : length;
    build(pat, length, rep, gp);
    $display("job pat=%08h len=%0d rep=%0d gap=%0d abort_at=%0d rst_at=%0d busy=%0d cycles=%0d",
             pat, length, rep, gp, abort_at, rst_at, busy, exp_q.size());
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.length  = 6'(length);
    bus.repeats = 8'(rep);
    bus.gap     = 8'(gp);
    step();
    for (int i = 1; i <= exp_q.size(); i++) begin
      check_rec($sformatf("cyc%0d", i), exp_q[i-1]);
      if (i == abort_at) begin
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_rec("after_abort", idle_r);
        return;
      end
      if (i == rst_at) begin
        bus.start = 1'b0;
        #14 rst = 1'b1;
        #1 check_rec("hold_before_rst_edge", exp_q[i-1]);
        step();
        rst = 1'b0;
        check_rec("after_rst", idle_r);
        return;
      end
      scramble_inputs();
      bus.start = busy && (i == 2 || i == len + 2);
      step();
    end
    bus.start = 1'b0;
    check_rec("idle_after_done", idle_r);
  endtask

  initial begin
    rec_t idle_r;
    int   ab;
    idle_r = '{ready: 1'b1, out: 1'b0, valid: 1'b0, fs: 1'b0, done: 1'b0};
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.pattern = 32'h1E16C;
    bus.length  = 6'd17;
    bus.repeats = 8'd0;
    bus.gap     = 8'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_rec($sformatf("reset%0d", k), idle_r);
    end
    rst = 1'b0;

    run_job(32'h1E16C, 17, 0, 0, 0, 0, 1'b0);
    run_job(32'h5, 3, 2, 3, 0, 0, 1'b1);
    run_job(32'hC, 4, 1, 0, 0, 0, 1'b1);
    run_job($urandom, 40, 0, 0, 0, 0, 1'b0);
    run_job($urandom, 0, 3, 2, 0, 0, 1'b0);
    run_job(32'h1E16C, 17, 0, 0, 0, 6, 1'b0);
    run_job(32'h1E16C, 17, 0, 0, 6, 0, 1'b0);
    run_job(32'h5, 3, 2, 3, 5, 0, 1'b0);
    run_job(32'h5, 3, 0, 0, 4, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_job($urandom, $urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, 4),
              ab, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-pattern transmitter: accepts a parallel pattern word plus a length, repeat count and inter-frame gap, then shifts the pattern out MSB-first, one bit per clock. It is the stimulus and transmit end for the team's serial sequence-detector FSMs. It drives their single-bit `in` line with `out`, and `out_valid` marks the bits that belong to a frame. A start/ready handshake lets a host or bench queue exactly one job at a time.

## Interface
- `MAX_LEN`, 32: maximum pattern length in bits; `LEN_W = $clog2(MAX_LEN)+1`.
- `CNT_W`, 8: width of the repeat and gap counters.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high. Takes effect only at a rising edge and overrides all other inputs.
- `start`  in  1: job request; accepted only in a cycle where `ready`=1.
- `abort`  in  1: cancel the current job; ignored in IDLE.
- `pattern`  in  MAX_LEN: pattern bits; the active field is bits [len-1:0].
- `length`  in  LEN_W: bits per frame, len. Values above MAX_LEN are clamped to MAX_LEN.
- `repeats`  in  CNT_W: extra frames. Total frames sent = `repeats`+1.
- `gap`  in  CNT_W: idle cycles inserted between frames.
- `ready`  out  1: high in IDLE only.
- `out`  out  1: serial data. It is 0 whenever `out_valid`=0.
- `out_valid`  out  1: high while a frame bit is on `out`.
- `frame_start`  out  1: high together with the first bit of each frame.
- `done`  out  1: one-cycle pulse when a job completes normally.

## Operation
- All outputs are registered. Reset values: `ready`=1, `out`=0, `out_valid`=0, `frame_start`=0, `done`=0. Reset returns the FSM to IDLE.
- FSM states are IDLE, SEND, GAP and DONE.
- **IDLE**
  - On `start`, capture `pattern`, the clamped `length`, `repeats` and `gap`.
  - If the clamped length is 0, go to DONE. Otherwise go to SEND with bit index = len-1 and frames_left = `repeats`.
- **SEND**
  - Drive `out` = pattern[idx] with `out_valid`=1; `frame_start`=1 when idx = len-1.
  - Decrement idx each cycle.
  - After the bit with idx=0:
    - if frames_left=0, go to DONE;
    - else if gap=0, go to SEND (idx reloads to len-1, back-to-back);
    - else go to GAP. In both non-final cases frames_left decrements.
- **GAP**
  - Drive `out`=0 and `out_valid`=0 for exactly `gap` cycles, then go to SEND with idx = len-1.
- **DONE**
  - `done`=1 and `ready`=0 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `abort` in SEND, GAP or DONE:
  - at the next edge, go to IDLE with all outputs at their reset values and `ready`=1;
  - no `done` pulse is produced, except when `abort` arrives while already in DONE, where the pulse already in progress is allowed to complete.
- `rst` together with `start` or `abort`: reset wins.
- Changes on the captured inputs after acceptance have no effect on the job in progress.

## Timing
- `start` sampled high at edge T (with `ready`=1) → first bit on `out` with `out_valid`=1 in the cycle after T.
- A frame occupies exactly len consecutive cycles, with no bubbles inside a frame.
- Job duration from the first bit to the `done` pulse (inclusive) = (repeats+1)·len + repeats·gap + 1 cycles.
- `ready` is low from edge T+1 through the `done` cycle, and high again the cycle after `done`.
  - A new `start` presented in that cycle is accepted, giving back-to-back jobs separated by one idle cycle.
- Length 0: `done` is high in the cycle after T, with no valid bits.
- `rst` raised partway through a cycle has no effect until the next rising edge. Outputs change only at that edge.

## Test plan
- Reset:
  - hold `rst`=1 for 2 cycles with `start`=1 → `ready`=1, `out`=`out_valid`=`frame_start`=`done`=0;
  - then the first post-reset `start` is accepted.
- Single frame: pattern=0x1E16C, length=17, repeats=0, gap=0 →
  - `out` over 17 valid cycles is 11110000101101100;
  - `frame_start` on cycle 1 only; `done` on cycle 18; `ready` back on cycle 19.
- Repeat with gap: pattern=0b101, length=3, repeats=2, gap=3 →
  - valid bits 101 at cycles 1-3, 7-9 and 13-15; `out_valid`=0 at cycles 4-6 and 10-12;
  - `done` at cycle 16; `frame_start` at cycles 1, 7 and 13.
- Back-to-back and clamping:
  - pattern=0b1100, length=4, repeats=1, gap=0 → contiguous 11001100, `frame_start` at cycles 1 and 5, `done` at 9;
  - length=40 → exactly 32 valid bits;
  - length=0 → `done` at cycle 1, no valid bits.
- Mid-job interruption:
  - during the single-frame job, raise `rst` 15 ns into the 6th bit cycle → outputs hold until the next edge, then take reset values, with no `done`;
  - repeat with `abort` at bit 6 → the same response, and `ready`=1 the next cycle.
- Busy protection: pulse `start` with a different pattern during SEND and during GAP → ignored, and the original sequence completes unchanged.
